alu_wb_stage: RTL and testbench

- Execute/writeback stage directly downstream of the 16-bit ALU.
- Captures ALU_OUT and FLAG_OUT into a 2-entry skid buffer.
- Holds the architectural flag register {S,Z,C,V} and evaluates conditional branches against it.
- Presents register-file writeback entries to the writeback consumer through a valid/ready handshake.

---
 rtl/alu_wb_stage_if.sv | 40 ++++
 rtl/alu_wb_stage.sv | 139 +++++++++++++
 tb/tb_alu_wb_stage.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_wb_stage_if.sv
// rtl/alu_wb_stage_if.sv - upstream entry and writeback handshake bundle for alu_wb_stage
interface alu_wb_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
);
  // Upstream entry from the ALU
  logic              IN_VALID;
  logic              IN_READY;
  logic [DATA_W-1:0] ALU_OUT;
  logic [3:0]        FLAG_OUT;
  logic [3:0]        S_ALU;
  logic [REG_AW-1:0] DEST_REG;
  logic              WE_REG;
  logic              WE_FLAG;
  logic              BR_EN;
  logic [2:0]        BR_COND;

  // Writeback head entry towards the register file
  logic              WB_VALID;
  logic              WB_READY;
  logic [DATA_W-1:0] WB_DATA;
  logic [REG_AW-1:0] WB_DEST;
  logic              WB_WE;
  logic              BR_TAKEN;

  // Architectural flag register {S,Z,C,V}
  logic [3:0]        FLAGS;

  modport master (
    output IN_VALID, ALU_OUT, FLAG_OUT, S_ALU, DEST_REG, WE_REG, WE_FLAG,
           BR_EN, BR_COND, WB_READY,
    input  IN_READY, WB_VALID, WB_DATA, WB_DEST, WB_WE, BR_TAKEN, FLAGS
  );

  modport slave (
    input  IN_VALID, ALU_OUT, FLAG_OUT, S_ALU, DEST_REG, WE_REG, WE_FLAG,
           BR_EN, BR_COND, WB_READY,
    output IN_READY, WB_VALID, WB_DATA, WB_DEST, WB_WE, BR_TAKEN, FLAGS
  );
endinterface

// File: rtl/alu_wb_stage.sv
// rtl/alu_wb_stage.sv - ALU execute/writeback stage: 2-entry skid buffer, flag register, branch resolve; optional FLAG_FWD_EN
module alu_wb_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input logic          CLK,
  input logic          RST,
  alu_wb_stage_if.slave bus
);

  localparam logic [3:0] S_ALU_NOP = 4'b1111;
  localparam logic [1:0] DEPTH     = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] dest;
    logic              we;
    logic              br;
  } entry_t;

  localparam entry_t ENTRY_EMPTY = '0;

  // slot0 is always the head; slot1 only holds data when count == 2
  entry_t     slot0;
  entry_t     slot1;
  logic [1:0] count;
  logic [3:0] flags_r;

  logic       accept;
  logic       pop;
  logic       flag_wr;
  logic [3:0] cond_flags;
  logic       br_new;
  entry_t     new_entry;

  // Condition table over {S,Z,C,V}
  function automatic logic eval_cond(input logic [2:0] sel, input logic [3:0] f);
    logic s, z, c, v, hit;
    s = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    hit = 1'b0;
    case (sel)
      3'b000: hit = 1'b1;
      3'b001: hit = z;
      3'b010: hit = !z;
      3'b011: hit = c;
      3'b100: hit = !c;
      3'b101: hit = s;
      3'b110: hit = s ^ v;
      3'b111: hit = !(s ^ v);
    endcase
    return hit;
  endfunction

  // Ready depends only on reset and registered occupancy, never on WB_READY
  assign bus.IN_READY = !RST && (count < DEPTH);
  assign accept       = bus.IN_VALID && bus.IN_READY;
  assign pop          = (count != 2'd0) && bus.WB_READY;
  assign flag_wr      = accept && bus.WE_FLAG && (bus.S_ALU != S_ALU_NOP);

  // Branch sees the flags from before this entry, unless fused compare-and-branch is built in
  always_comb begin
    cond_flags = flags_r;
`ifdef FLAG_FWD_EN
    if (bus.BR_EN && bus.WE_FLAG && (bus.S_ALU != S_ALU_NOP)) begin
      cond_flags = bus.FLAG_OUT;
    end
`endif
    br_new = bus.BR_EN && eval_cond(bus.BR_COND, cond_flags);
  end

  // Pack the incoming entry as it will sit in the buffer
  always_comb begin
    new_entry      = ENTRY_EMPTY;
    new_entry.data = bus.ALU_OUT;
    new_entry.dest = bus.DEST_REG;
    new_entry.we   = bus.WE_REG;
    new_entry.br   = br_new;
  end

  // Architectural flags update at acceptance; no-ops and non-flag entries leave them alone
  always_ff @(posedge CLK) begin
    if (RST) begin
      flags_r <= 4'b0000;
    end else if (flag_wr) begin
      flags_r <= bus.FLAG_OUT;
    end
  end

  // FIFO occupancy and slot movement; vacated slots are cleared so idle outputs read zero
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= 2'd0;
      slot0 <= ENTRY_EMPTY;
      slot1 <= ENTRY_EMPTY;
    end else begin
      case ({accept, pop})
        2'b10: begin
          if (count == 2'd0) begin
            slot0 <= new_entry;
          end else begin
            slot1 <= new_entry;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == DEPTH) begin
            slot0 <= slot1;
          end else begin
            slot0 <= ENTRY_EMPTY;
          end
          slot1 <= ENTRY_EMPTY;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Head leaves while a new entry arrives: occupancy unchanged, order kept
          if (count == 2'd1) begin
            slot0 <= new_entry;
          end else begin
            slot0 <= slot1;
            slot1 <= new_entry;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.WB_VALID = (count != 2'd0);
  assign bus.WB_DATA  = slot0.data;
  assign bus.WB_DEST  = slot0.dest;
  assign bus.WB_WE    = slot0.we;
  assign bus.BR_TAKEN = slot0.br;
  assign bus.FLAGS    = flags_r;

endmodule

// File: tb/tb_alu_wb_stage.sv
// tb/tb_alu_wb_stage.sv - directed plus randomized check of alu_wb_stage against a queue model
module tb_alu_wb_stage;

  logic clk;
  logic rst;

  alu_wb_stage_if #(.DATA_W(16), .REG_AW(3)) bus ();

  alu_wb_stage #(.DATA_W(16), .REG_AW(3)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] data;
    logic [2:0]  dest;
    logic        we;
    logic        br;
  } ref_entry_t;

  ref_entry_t  ref_q[$];
  logic [3:0]  ref_flags;
  logic        ref_after_rst;
  int          n_cmp;
  int          n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic ref_cond(input logic [2:0] sel, input logic [3:0] f);
    logic s, z, c, v;
    {s, z, c, v} = f;
    if (sel == 3'd0) return 1'b1;
    if (sel == 3'd1) return z;
    if (sel == 3'd2) return !z;
    if (sel == 3'd3) return c;
    if (sel == 3'd4) return !c;
    if (sel == 3'd5) return s;
    if (sel == 3'd6) return s != v;
    return s == v;
  endfunction

  // Predict the state after the coming edge from the inputs now applied
  task automatic predict();
    logic       acc;
    logic       pp;
    logic       upd;
    logic [3:0] src;
    ref_entry_t e;
    if (rst) begin
      ref_q.delete();
      ref_flags     = 4'b0000;
      ref_after_rst = 1'b1;
      return;
    end
    ref_after_rst = 1'b0;
    acc = bus.IN_VALID && (ref_q.size() < 2);
    pp  = (ref_q.size() > 0) && bus.WB_READY;
    upd = bus.WE_FLAG && (bus.S_ALU != 4'b1111);
    src = ref_flags;
`ifdef FLAG_FWD_EN
    if (bus.BR_EN && upd) src = bus.FLAG_OUT;
`endif
    if (pp) void'(ref_q.pop_front());
    if (acc) begin
      e.data = bus.ALU_OUT;
      e.dest = bus.DEST_REG;
      e.we   = bus.WE_REG;
      e.br   = bus.BR_EN && ref_cond(bus.BR_COND, src);
      ref_q.push_back(e);
      if (upd) ref_flags = bus.FLAG_OUT;
    end
  endtask

  task automatic compare_all();
    check("in_ready", bus.IN_READY, !rst && (ref_q.size() < 2));
    check("wb_valid", bus.WB_VALID, ref_q.size() != 0);
    check("flags", bus.FLAGS, ref_flags);
    if (ref_q.size() != 0) begin
      check("wb_data", bus.WB_DATA, ref_q[0].data);
      check("wb_dest", bus.WB_DEST, ref_q[0].dest);
      check("wb_we", bus.WB_WE, ref_q[0].we);
      check("br_taken", bus.BR_TAKEN, ref_q[0].br);
    end else if (ref_after_rst) begin
      check("rst_wb_data", bus.WB_DATA, 0);
      check("rst_wb_dest", bus.WB_DEST, 0);
      check("rst_wb_we", bus.WB_WE, 0);
      check("rst_br_taken", bus.BR_TAKEN, 0);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, clock once, then compare at the next falling edge
  task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] f,
                       input logic [3:0] op, input logic [2:0] dst, input logic wr,
                       input logic wf, input logic be, input logic [2:0] bc,
                       input logic rdy, input logic r);
    rst          = r;
    bus.IN_VALID = v;
    bus.ALU_OUT  = d;
    bus.FLAG_OUT = f;
    bus.S_ALU    = op;
    bus.DEST_REG = dst;
    bus.WE_REG   = wr;
    bus.WE_FLAG  = wf;
    bus.BR_EN    = be;
    bus.BR_COND  = bc;
    bus.WB_READY = rdy;
    predict();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic exp_fused;
    n_cmp         = 0;
    n_err         = 0;
    ref_flags     = 4'b0000;
    ref_after_rst = 1'b0;
    rst           = 1'b1;
    bus.IN_VALID  = 1'b0;
    bus.ALU_OUT   = '0;
    bus.FLAG_OUT  = '0;
    bus.S_ALU     = 4'b1111;
    bus.DEST_REG  = '0;
    bus.WE_REG    = 1'b0;
    bus.WE_FLAG   = 1'b0;
    bus.BR_EN     = 1'b0;
    bus.BR_COND   = '0;
    bus.WB_READY  = 1'b0;
    @(negedge clk);

    // Reset state
    drive(1, 16'hffff, 4'hf, 4'h0, 3'd7, 1, 1, 1, 3'd0, 1, 1);
    drive(1, 16'hffff, 4'hf, 4'h0, 3'd7, 1, 1, 1, 3'd0, 1, 1);
    check("reset_in_ready", bus.IN_READY, 0);
    drive(0, 16'h0, 4'h0, 4'hf, 3'd0, 0, 0, 0, 3'd0, 1, 0);
    check("idle_in_ready", bus.IN_READY, 1);

    // Single entry, one edge of latency
    drive(1, 16'h1234, 4'h0, 4'h0, 3'd3, 1, 0, 0, 3'd0, 1, 0);
    check("single_valid", bus.WB_VALID, 1);
    check("single_data", bus.WB_DATA, 16'h1234);
    check("single_dest", bus.WB_DEST, 3);
    check("single_we", bus.WB_WE, 1);
    drive(0, 16'h0, 4'h0, 4'hf, 3'd0, 0, 0, 0, 3'd0, 1, 0);
    check("single_drained", bus.WB_VALID, 0);

    // Back-pressure: A, B fill the buffer, C is refused until space frees
    drive(1, 16'h0001, 4'h0, 4'h0, 3'd1, 1, 0, 0, 3'd0, 0, 0);
    drive(1, 16'h0002, 4'h0, 4'h0, 3'd2, 1, 0, 0, 3'd0, 0, 0);
    check("full_in_ready", bus.IN_READY, 0);
    drive(1, 16'h0003, 4'h0, 4'h0, 3'd4, 1, 0, 0, 3'd0, 0, 0);
    check("stall_head_a", bus.WB_DATA, 16'h0001);
    drive(1, 16'h0003, 4'h0, 4'h0, 3'd4, 1, 0, 0, 3'd0, 0, 0);
    check("stall_head_a_again", bus.WB_DATA, 16'h0001);
    drive(1, 16'h0003, 4'h0, 4'h0, 3'd4, 1, 0, 0, 3'd0, 1, 0);
    check("drain_head_b", bus.WB_DATA, 16'h0002);
    drive(1, 16'h0003, 4'h0, 4'h0, 3'd4, 1, 0, 0, 3'd0, 1, 0);
    check("drain_head_c", bus.WB_DATA, 16'h0003);
    drive(0, 16'h0, 4'h0, 4'hf, 3'd0, 0, 0, 0, 3'd0, 1, 0);
    check("drain_empty", bus.WB_VALID, 0);

    // Flags: SUB updates, no-op with WE_FLAG does not
    drive(1, 16'h0000, 4'b0100, 4'b0010, 3'd0, 1, 1, 0, 3'd0, 1, 0);
    check("flags_sub", bus.FLAGS, 4'b0100);
    drive(1, 16'h0000, 4'b0000, 4'b1111, 3'd0, 0, 1, 0, 3'd0, 1, 0);
    check("flags_nop_hold", bus.FLAGS, 4'b0100);

    // Branch conditions against FLAGS = S only
    drive(1, 16'h0000, 4'b1000, 4'b0010, 3'd0, 0, 1, 0, 3'd0, 1, 0);
    drive(1, 16'h0010, 4'h0, 4'h0, 3'd0, 0, 0, 1, 3'b110, 1, 0);
    check("br_lt", bus.BR_TAKEN, 1);
    drive(1, 16'h0011, 4'h0, 4'h0, 3'd0, 0, 0, 1, 3'b111, 1, 0);
    check("br_ge", bus.BR_TAKEN, 0);
    drive(1, 16'h0012, 4'h0, 4'h0, 3'd0, 0, 0, 1, 3'b001, 1, 0);
    check("br_z", bus.BR_TAKEN, 0);
    drive(1, 16'h0013, 4'h0, 4'h0, 3'd0, 0, 0, 0, 3'b000, 1, 0);
    check("br_disabled", bus.BR_TAKEN, 0);
    check("br_entry_valid", bus.WB_VALID, 1);

    // Fused compare-and-branch
    drive(1, 16'h0000, 4'b0000, 4'b0010, 3'd0, 0, 1, 0, 3'd0, 1, 0);
    drive(1, 16'h0020, 4'b0100, 4'b0010, 3'd0, 0, 1, 1, 3'b001, 1, 0);
`ifdef FLAG_FWD_EN
    exp_fused = 1'b1;
`else
    exp_fused = 1'b0;
`endif
    check("fused_br", bus.BR_TAKEN, exp_fused);
    check("fused_flags", bus.FLAGS, 4'b0100);

    // Reset asserted while the buffer is full and stalled
    drive(1, 16'h0030, 4'b1111, 4'b0010, 3'd5, 1, 1, 0, 3'd0, 0, 0);
    drive(1, 16'h0031, 4'b0000, 4'b0010, 3'd6, 1, 0, 0, 3'd0, 0, 0);
    check("midstall_flags", bus.FLAGS, 4'b1111);
    check("midstall_full", bus.IN_READY, 0);
    drive(1, 16'h0032, 4'b0000, 4'b0010, 3'd6, 1, 1, 0, 3'd0, 1, 1);
    check("midstall_rst_valid", bus.WB_VALID, 0);
    check("midstall_rst_flags", bus.FLAGS, 0);
    check("midstall_rst_ready", bus.IN_READY, 0);
    drive(0, 16'h0, 4'h0, 4'hf, 3'd0, 0, 0, 0, 3'd0, 0, 0);
    check("midstall_release_ready", bus.IN_READY, 1);

    // Randomized traffic against the queue model
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 3) != 0),
            16'($urandom),
            4'($urandom),
            ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom),
            3'($urandom),
            1'($urandom),
            1'($urandom),
            1'($urandom),
            3'($urandom),
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
